// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory arbiter: bus/map defaults, the response
// state encoding, and the meaning of the last-granted flag.
package mem_sys_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam logic [31:0] RAM_BASE_DEF   = 32'h1000_0000;

  // Response state: which port (if any) receives a response this cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_state_e;

  // Encoding of the last-granted flag.
  localparam logic LAST_IF = 1'b0;
  localparam logic LAST_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Request selection for the memory arbiter. It turns two requests plus the
// last-granted flag into a one-hot grant (bit 0 = IF, bit 1 = DM).
//
// Build option MEM_ARB_ROUND_ROBIN_EN:
//   defined   - on a collision the port that was not granted last wins
//   undefined - fixed priority, DM always wins a collision
module mem_arb_pick
  import mem_sys_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // The last-granted flag only matters for alternation.
  logic unused_last;
  assign unused_last = last;
`endif

  // Pick at most one requester; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      gnt = (last == LAST_DM) ? 2'b01 : 2'b10;
`else
      gnt = 2'b10;
`endif
    end else if (if_req) begin
      gnt = 2'b01;
    end else if (dm_req) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one combinational-read memory between an
// instruction-fetch port and a data port. Grants are combinational, the
// response (read data or write acknowledge) follows one cycle later.
// Writes below RAM_BASE are dropped and acknowledged with dm_err_o.
//
// Handshake: a port holds req and its inputs stable until gnt is seen high in
// the same cycle; exactly one rvalid pulse follows each grant on the next
// cycle, and a new grant may coincide with that response cycle.
//
// Build option MEM_ARB_ROUND_ROBIN_EN selects alternating collision
// resolution (see mem_arb_pick); the default is DM-first priority.
// last_o and state_o expose the arbiter and response FSM state.
module mem_arbiter
  import mem_sys_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = DATA_WIDTH'(RAM_BASE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  last_o,
  output resp_state_e           state_o
);

  logic [1:0]            pick_gnt;
  logic                  gnt_if;
  logic                  gnt_dm;
  logic                  dm_to_rom;
  logic                  last_q;
  resp_state_e           state_q;
  resp_state_e           state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  mem_arb_pick u_pick (
    .if_req (if_req_i),
    .dm_req (dm_req_i),
    .last   (last_q),
    .gnt    (pick_gnt)
  );

  // Reset blocks grants combinationally so nothing is issued while held.
  assign gnt_if    = rst_n & pick_gnt[0];
  assign gnt_dm    = rst_n & pick_gnt[1];
  assign dm_to_rom = (dm_addr_i < RAM_BASE);

  assign if_gnt_o = gnt_if;
  assign dm_gnt_o = gnt_dm;

  // Memory bus: granted port drives it, otherwise the last values are held.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if (gnt_if) begin
      mem_addr_o = if_addr_i;
    end else if (gnt_dm) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_we_o    = dm_we_i & ~dm_to_rom;
    end
  end

  // Response FSM next state: driven purely by this cycle's grant.
  always_comb begin
    state_d = IDLE;
    if (gnt_if) begin
      state_d = RESP_IF;
    end else if (gnt_dm) begin
      state_d = RESP_DM;
    end
  end

  // Response FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture read data / error flag, held bus values and last-granted port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= LAST_DM;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (gnt_if) begin
      last_q  <= LAST_IF;
      addr_q  <= if_addr_i;
      rdata_q <= mem_rdata_i;
      err_q   <= 1'b0;
    end else if (gnt_dm) begin
      last_q  <= LAST_DM;
      addr_q  <= dm_addr_i;
      wdata_q <= dm_wdata_i;
      rdata_q <= dm_we_i ? '0 : mem_rdata_i;
      err_q   <= dm_we_i & dm_to_rom;
    end
  end

  assign if_rvalid_o = (state_q == RESP_IF);
  assign dm_rvalid_o = (state_q == RESP_DM);
  assign if_rdata_o  = if_rvalid_o ? rdata_q : '0;
  assign dm_rdata_o  = dm_rvalid_o ? rdata_q : '0;
  assign dm_err_o    = dm_rvalid_o & err_q;
  assign last_o      = last_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;
  import mem_sys_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        last;
  resp_state_e state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tb_mem [16];

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_gnt_o    (dm_gnt),
    .dm_rvalid_o (dm_rvalid),
    .dm_rdata_o  (dm_rdata),
    .dm_err_o    (dm_err),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .last_o      (last),
    .state_o     (state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural memory: combinational read, write on the clock edge.
  assign mem_rdata = tb_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bit prev_dm;
    bit exp_dm;
    for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
    tb_mem[1] = 32'h0000_0013;
    tb_mem[4] = 32'hAAAA_AAAA;

    // Reset held with both requests active: nothing may be granted.
    rst_n    = 1'b0;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    if_addr  = 32'h0000_0004;
    dm_we    = 1'b0;
    dm_addr  = 32'h1000_0008;
    dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_last", last, 1);
    chk("rst_state", state, IDLE);

    @(negedge clk);
    rst_n  = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;

    // Lone IF read of ROM address 4.
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk("if_rd_gnt", if_gnt, 1);
    chk("if_rd_dm_gnt", dm_gnt, 0);
    chk("if_rd_mem_addr", mem_addr, 32'h0000_0004);
    chk("if_rd_mem_we", mem_we, 0);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("if_rd_rvalid", if_rvalid, 1);
    chk("if_rd_rdata", if_rdata, 32'h0000_0013);
    chk("if_rd_dm_rvalid", dm_rvalid, 0);
    chk("if_rd_gnt_off", if_gnt, 0);
    chk("if_rd_addr_hold", mem_addr, 32'h0000_0004);
    chk("if_rd_last", last, 0);
    chk("if_rd_state", state, RESP_IF);

    // DM write to RAM then back-to-back read-back.
    @(negedge clk);
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h1000_0008;
    dm_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt", dm_gnt, 1);
    chk("wr_if_gnt", if_gnt, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h1000_0008);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    dm_we = 1'b0;
    #1;
    chk("rb_gnt", dm_gnt, 1);
    chk("rb_mem_we", mem_we, 0);
    chk("wr_ack_rvalid", dm_rvalid, 1);
    chk("wr_ack_rdata", dm_rdata, 0);
    chk("wr_ack_err", dm_err, 0);
    @(negedge clk);
    dm_req = 1'b0;
    #1;
    chk("rb_rvalid", dm_rvalid, 1);
    chk("rb_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("rb_err", dm_err, 0);
    chk("rb_mem_we_idle", mem_we, 0);
    chk("rb_wdata_hold", mem_wdata, 32'hDEAD_BEEF);

    // DM write to ROM: granted, dropped, acknowledged with error.
    @(negedge clk);
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0010;
    dm_wdata = 32'h1234_5678;
    #1;
    chk("rom_wr_gnt", dm_gnt, 1);
    chk("rom_wr_mem_we", mem_we, 0);
    chk("rom_wr_mem_addr", mem_addr, 32'h0000_0010);
    @(negedge clk);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    #1;
    chk("rom_wr_rvalid", dm_rvalid, 1);
    chk("rom_wr_err", dm_err, 1);
    chk("rom_wr_rdata", dm_rdata, 0);
    @(negedge clk);
    #1;
    chk("rom_wr_rvalid_off", dm_rvalid, 0);
    chk("rom_wr_err_off", dm_err, 0);
    chk("rom_untouched", tb_mem[4], 32'hAAAA_AAAA);

    // Both ports requesting for 6 cycles (last currently DM).
    if_addr = 32'h0000_0004;
    dm_addr = 32'h1000_0008;
    dm_we   = 1'b0;
    prev_dm = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_dm = (i % 2) == 1;
`else
      exp_dm = 1'b1;
`endif
      chk($sformatf("both_if_gnt_%0d", i), if_gnt, !exp_dm);
      chk($sformatf("both_dm_gnt_%0d", i), dm_gnt, exp_dm);
      if (i > 0) begin
        chk($sformatf("both_dm_rvalid_%0d", i), dm_rvalid, prev_dm);
        chk($sformatf("both_if_rvalid_%0d", i), if_rvalid, !prev_dm);
      end
      prev_dm = exp_dm;
    end
    @(negedge clk);
    if_req = 1'b0;
    dm_req = 1'b0;
    #1;
    chk("both_last_rvalid", dm_rvalid, 1);
    chk("both_last_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("both_last_flag", last, 1);

    // Reset during the response cycle of an IF grant.
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk("inflight_gnt", if_gnt, 1);
    @(posedge clk);
    #1;
    chk("inflight_rvalid", if_rvalid, 1);
    rst_n  = 1'b0;
    if_req = 1'b0;
    #1;
    chk("async_rst_rvalid", if_rvalid, 0);
    chk("async_rst_rdata", if_rdata, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_last", last, 1);
    chk("async_rst_state", state, IDLE);
    if_req = 1'b1;
    #1;
    chk("rst_req_no_gnt", if_gnt, 0);
    chk("rst_req_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_if_rvalid_%0d", i), if_rvalid, 0);
      chk($sformatf("post_rst_dm_rvalid_%0d", i), dm_rvalid, 0);
    end

    // New request after reset gets a normal response.
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk("post_rst_gnt", if_gnt, 1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("post_rst_rvalid", if_rvalid, 1);
    chk("post_rst_rdata", if_rdata, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
